parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//  Shares one barrier gate between an entry lane and an exit lane of the car park.
//  Arbitrates lane requests round-robin and sequences each granted lane through auth/open/close.
//  Tracks lot occupancy against capacity and blocks entry when the lot is full.
//  Sits above the per-lane password/sensor logic; drives the shared barrier actuator.
// PARAMETERS
//  CAPACITY      8   number of parking slots
//  CNT_W         4   occupancy width; must satisfy 2**CNT_W > CAPACITY
//  AUTH_CYCLES   16  max cycles waiting for entry_pass_ok after an entry grant
//  OPEN_CYCLES   32  max cycles the gate stays open waiting for car_cleared
//  CLOSE_CYCLES  4   gate-settle cycles after closing, before the next arbitration
// PORTS
//  clock_in       in   1      system clock, rising edge
//  rst_in         in   1      reset, asynchronous, active-low
//  entry_req      in   1      level; a car is at the entry front sensor
//  exit_req       in   1      level; a car is at the exit front sensor
//  entry_pass_ok  in   1      1-cycle pulse; entry password verified
//  car_cleared    in   1      1-cycle pulse; back sensor of the granted lane passed
//  gate_open      out  1      barrier open command
//  entry_grant    out  1      entry lane owns the gate
//  exit_grant     out  1      exit lane owns the gate
//  occupancy      out  CNT_W  cars currently parked
//  lot_full       out  1      occupancy == CAPACITY
//  timeout_err    out  1      1-cycle pulse on an auth or open timeout
// BEHAVIOUR
//  Reset: all outputs 0, occupancy 0, state IDLE, rr pointer = entry-first, timer 0.
//  All outputs are registered. A request sampled in IDLE at edge N gives a grant from edge N+1.
//  States:
//   IDLE   eligible_entry = entry_req & ~lot_full; eligible_exit = exit_req.
//          If one lane is eligible, grant it. If both are, grant the rr-pointer lane.
//          Entry grant -> AUTH, timer=AUTH_CYCLES. Exit grant -> OPEN, timer=OPEN_CYCLES.
//          The rr pointer flips to the other lane whenever a grant is issued.
//   AUTH   entry_grant=1, gate_open=0. entry_pass_ok -> OPEN, timer=OPEN_CYCLES.
//          When the timer reaches 0 -> CLOSE with a timeout_err pulse.
//   OPEN   gate_open=1 and the granted lane's grant=1. car_cleared -> CLOSE:
//          entry adds 1 (saturates at CAPACITY); exit subtracts 1 (saturates at 0).
//          Timer reaches 0 -> CLOSE with a timeout_err pulse and occupancy unchanged.
//   CLOSE  gate_open=0, both grants=0, timer=CLOSE_CYCLES. IDLE when the timer reaches 0.
//  Timer: one shared down-counter, decremented every cycle outside IDLE.
//  A "timeout" is the cycle the timer reads 0.
//  Same cycle as timeout: entry_pass_ok or car_cleared wins, timeout is not flagged.
//  entry_pass_ok outside AUTH and car_cleared outside OPEN are ignored.
//  lot_full is updated the same edge occupancy changes.
//  Entry is blocked while lot_full=1; a pending entry_req waits in IDLE.
//  Exit is always eligible, including at occupancy 0 (counter saturates).
//  Requests that drop while granted do not abort the sequence; the timers bound it.
//  rst_in mid-operation: gate closes and occupancy clears asynchronously.
// STRUCTURE
//  Shared package parking_pkg: state encodings IDLE/AUTH/OPEN/CLOSE and the lane IDs.
//  The correct-password constants also live in parking_pkg for reuse by lane logic.
//  One sub-module: park_timer (loadable down-counter with load/value inputs and a zero flag).
//  The top level holds the FSM, rr pointer and occupancy counter.
// TESTING
//  entry_req=1 only, pass_ok 3 cyc later, car_cleared 5 cyc later
//   -> entry_grant, gate_open, occupancy 0->1, IDLE after 4 CLOSE cycles.
//  entry_req and exit_req both held from reset at occupancy 2
//   -> entry granted first, then exit, then entry (strict alternation).
//  Occupancy 8 with entry_req=1 -> lot_full=1, no entry grant; exit served -> occupancy 7.
//   Entry is granted next.
//  Entry granted, no pass_ok -> timeout_err pulse at cycle 16, gate never opens.
//   Occupancy unchanged, rr pointer now on exit.
//  Exit in OPEN, car_cleared on the same cycle the timer hits 0
//   -> no timeout_err, occupancy decremented.
//  rst_in low during OPEN
//   -> gate_open=0 and occupancy=0 immediately; first request after release behaves as from reset.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types for the car-park gate: FSM states, lane IDs, lane passwords.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AUTH  = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } state_e;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_e;

    localparam logic [15:0] ENTRY_PASSWORD = 16'h2719;
    localparam logic [15:0] EXIT_PASSWORD  = 16'h4801;

    function automatic int tmr_bits(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/parking_gate_arbiter_timer.sv
// Loadable down-counter shared by all gate phases; holds at zero.
module park_timer #(
    parameter int W = 6
) (
    input  logic         clock_in,
    input  logic         rst_in,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// One barrier shared by entry and exit lanes: round-robin grant,
// auth/open/close sequencing and lot occupancy tracking.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = 4,
    parameter int AUTH_CYCLES  = 16,
    parameter int OPEN_CYCLES  = 32,
    parameter int CLOSE_CYCLES = 4
) (
    input  logic             clock_in,
    input  logic             rst_in,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             entry_pass_ok,
    input  logic             car_cleared,
    output logic             gate_open,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             timeout_err
);

    localparam int TW = tmr_bits(AUTH_CYCLES, OPEN_CYCLES, CLOSE_CYCLES);
    localparam logic [TW-1:0] AUTH_LD  = TW'(AUTH_CYCLES);
    localparam logic [TW-1:0] OPEN_LD  = TW'(OPEN_CYCLES);
    localparam logic [TW-1:0] CLOSE_LD = TW'(CLOSE_CYCLES);
    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

    state_e state;
    lane_e  lane;
    lane_e  rr;

    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic [TW-1:0] tmr_count;
    logic          tmr_zero;

    logic pick_entry, pick_exit, pass_evt, clr_evt, tmo_evt, close_done;
    logic [CNT_W-1:0] occ_next;

    park_timer #(.W(TW)) u_timer (
        .clock_in (clock_in),
        .rst_in   (rst_in),
        .load     (tmr_load),
        .en       (state != IDLE),
        .value    (tmr_value),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Pulse inputs win over a timeout landing on the same cycle.
    always_comb begin
        pick_entry = (state == IDLE) && entry_req && !lot_full
                     && (!exit_req || rr == LANE_ENTRY);
        pick_exit  = (state == IDLE) && exit_req && !pick_entry;
        pass_evt   = (state == AUTH) && entry_pass_ok;
        clr_evt    = (state == OPEN) && car_cleared;
        tmo_evt    = tmr_zero && (((state == AUTH) && !entry_pass_ok)
                     || ((state == OPEN) && !car_cleared));
        close_done = (state == CLOSE) && (tmr_zero || tmr_count == TW'(1));
        tmr_load   = 1'b1;
        tmr_value  = '0;
        unique case (1'b1)
            pick_entry:         tmr_value = AUTH_LD;
            pick_exit,
            pass_evt:           tmr_value = OPEN_LD;
            clr_evt, tmo_evt:   tmr_value = CLOSE_LD;
            default:            tmr_load  = 1'b0;
        endcase
    end

    always_comb begin
        occ_next = occupancy;
        if (clr_evt) begin
            if (lane == LANE_ENTRY) begin
                occ_next = (occupancy >= CAP_C) ? CAP_C : occupancy + CNT_W'(1);
            end else begin
                occ_next = (occupancy == '0) ? '0 : occupancy - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            lane        <= LANE_ENTRY;
            rr          <= LANE_ENTRY;
            gate_open   <= 1'b0;
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            occupancy   <= '0;
            lot_full    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_evt;
            occupancy   <= occ_next;
            lot_full    <= (occ_next == CAP_C);
            case (state)
                IDLE: begin
                    if (pick_entry) begin
                        state       <= AUTH;
                        lane        <= LANE_ENTRY;
                        rr          <= LANE_EXIT;
                        entry_grant <= 1'b1;
                    end else if (pick_exit) begin
                        state      <= OPEN;
                        lane       <= LANE_EXIT;
                        rr         <= LANE_ENTRY;
                        exit_grant <= 1'b1;
                        gate_open  <= 1'b1;
                    end
                end
                AUTH: begin
                    if (pass_evt) begin
                        state     <= OPEN;
                        gate_open <= 1'b1;
                    end else if (tmo_evt) begin
                        state       <= CLOSE;
                        entry_grant <= 1'b0;
                    end
                end
                OPEN: begin
                    if (clr_evt || tmo_evt) begin
                        state       <= CLOSE;
                        gate_open   <= 1'b0;
                        entry_grant <= 1'b0;
                        exit_grant  <= 1'b0;
                    end
                end
                CLOSE: begin
                    if (close_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: vector table, corner sequences and
// random traffic against a phase/age reference model.
module tb_parking_gate_arbiter;

    localparam int CAP     = 8;
    localparam int AUTH_C  = 16;
    localparam int OPEN_C  = 32;
    localparam int CLOSE_C = 4;

    logic       clock_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       entry_pass_ok = 1'b0;
    logic       car_cleared = 1'b0;
    logic       gate_open, entry_grant, exit_grant, lot_full, timeout_err;
    logic [3:0] occupancy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock_in = ~clock_in;

    parking_gate_arbiter dut (
        .clock_in      (clock_in),
        .rst_in        (rst_in),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .entry_pass_ok (entry_pass_ok),
        .car_cleared   (car_cleared),
        .gate_open     (gate_open),
        .entry_grant   (entry_grant),
        .exit_grant    (exit_grant),
        .occupancy     (occupancy),
        .lot_full      (lot_full),
        .timeout_err   (timeout_err)
    );

    // Reference model: current phase, cycles spent in it, lane, next-up lane.
    typedef enum int {M_IDLE, M_AUTH, M_OPEN, M_CLOSE} mphase_e;
    mphase_e m_phase;
    int      m_age;
    int      m_occ;
    bit      m_lane_exit;
    bit      m_next_exit;
    bit      m_tout;

    typedef struct {
        bit er; bit xr; bit po; bit cc;
        bit go; bit eg; bit xg; int occ;
    } vec_t;
    vec_t tbl[14];

    task automatic model_reset();
        m_phase = M_IDLE; m_age = 0; m_occ = 0;
        m_lane_exit = 0; m_next_exit = 0; m_tout = 0;
    endtask

    task automatic model_step(input bit er, input bit xr, input bit po, input bit cc);
        bit want_entry;
        m_tout = 0;
        want_entry = er && (m_occ < CAP);
        case (m_phase)
            M_IDLE: begin
                if (want_entry && (!xr || !m_next_exit)) begin
                    m_phase = M_AUTH; m_lane_exit = 0; m_next_exit = 1; m_age = 0;
                end else if (xr) begin
                    m_phase = M_OPEN; m_lane_exit = 1; m_next_exit = 0; m_age = 0;
                end
            end
            M_AUTH: begin
                if (po) begin m_phase = M_OPEN; m_age = 0; end
                else if (m_age == AUTH_C) begin m_phase = M_CLOSE; m_age = 0; m_tout = 1; end
                else m_age++;
            end
            M_OPEN: begin
                if (cc) begin
                    if (!m_lane_exit && m_occ < CAP) m_occ++;
                    if (m_lane_exit && m_occ > 0) m_occ--;
                    m_phase = M_CLOSE; m_age = 0;
                end else if (m_age == OPEN_C) begin
                    m_phase = M_CLOSE; m_age = 0; m_tout = 1;
                end else m_age++;
            end
            default: begin
                if (m_age == CLOSE_C - 1) begin m_phase = M_IDLE; m_age = 0; end
                else m_age++;
            end
        endcase
    endtask

    function automatic logic [8:0] dut_vec();
        return {gate_open, entry_grant, exit_grant, lot_full, timeout_err, occupancy};
    endfunction

    function automatic logic [8:0] exp_vec();
        logic go, eg, xg;
        go = (m_phase == M_OPEN);
        eg = (m_phase == M_AUTH) || (go && !m_lane_exit);
        xg = go && m_lane_exit;
        return {go, eg, xg, m_occ == CAP, m_tout, 4'(m_occ)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit er, input bit xr, input bit po, input bit cc);
        entry_req = er; exit_req = xr; entry_pass_ok = po; car_cleared = cc;
        @(posedge clock_in);
        model_step(er, xr, po, cc);
        #1;
        chk("model", 32'(dut_vec()), 32'(exp_vec()));
        entry_pass_ok = 0; car_cleared = 0;
    endtask

    task automatic do_reset();
        rst_in = 0; entry_req = 0; exit_req = 0; entry_pass_ok = 0; car_cleared = 0;
        #1;
        model_reset();
        chk("reset", 32'(dut_vec()), 32'(exp_vec()));
        @(posedge clock_in);
        #1 rst_in = 1;
    endtask

    task automatic admit();
        int n = 0;
        while (!entry_grant && n < 20) begin cycle(1, 0, 0, 0); n++; end
        chk("admit_bound", 32'(n < 20), 32'd1);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        repeat (CLOSE_C) cycle(0, 0, 0, 0);
    endtask

    task automatic depart();
        int n = 0;
        while (!exit_grant && n < 20) begin cycle(0, 1, 0, 0); n++; end
        chk("depart_bound", 32'(n < 20), 32'd1);
        cycle(0, 0, 0, 1);
        repeat (CLOSE_C) cycle(0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        bit prev_eg, prev_xg;
        int opened, pulses, pulse_at;

        // Single entry: pass_ok 3 cycles after grant, car_cleared 5 after that.
        tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 1, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 1, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{1, 0, 0, 0, 0, 1, 0, 1};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].er, tbl[i].xr, tbl[i].po, tbl[i].cc);
            chk($sformatf("tbl%0d", i),
                {23'd0, gate_open, entry_grant, exit_grant, lot_full, timeout_err, occupancy},
                {23'd0, tbl[i].go, tbl[i].eg, tbl[i].xg, 1'b0, 1'b0, 4'(tbl[i].occ)});
        end

        // Both lanes requesting at occupancy 2 with the pointer on entry.
        do_reset();
        admit(); admit(); admit(); depart();
        chk("alt_occ", 32'(occupancy), 32'd2);
        prev_eg = 0; prev_xg = 0;
        for (int i = 0; i < 25; i++) begin
            cycle(1, 1, m_phase == M_AUTH, m_phase == M_OPEN);
            if (entry_grant && !prev_eg) order.push_back(0);
            if (exit_grant && !prev_xg) order.push_back(1);
            prev_eg = entry_grant; prev_xg = exit_grant;
        end
        chk("alt_count", 32'(order.size() >= 3), 32'd1);
        while (order.size() < 3) order.push_back(9);
        chk("alt_1st", 32'(order[0]), 32'd0);
        chk("alt_2nd", 32'(order[1]), 32'd1);
        chk("alt_3rd", 32'(order[2]), 32'd0);

        // Full lot: entry held off, exit served, then entry granted.
        do_reset();
        repeat (CAP) admit();
        chk("full_occ", 32'(occupancy), 32'(CAP));
        chk("full_flag", 32'(lot_full), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 0);
            chk("full_block", 32'(entry_grant), 32'd0);
        end
        cycle(1, 1, 0, 0);
        chk("full_exit_grant", 32'(exit_grant), 32'd1);
        cycle(1, 0, 0, 1);
        chk("full_exit_occ", 32'(occupancy), 32'(CAP - 1));
        chk("full_clear", 32'(lot_full), 32'd0);
        repeat (CLOSE_C) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("full_entry_next", 32'(entry_grant), 32'd1);

        // Auth timeout: no pass_ok after an entry grant.
        do_reset();
        cycle(1, 0, 0, 0);
        opened = 0; pulses = 0; pulse_at = -1;
        for (int i = 0; i < 25; i++) begin
            cycle(0, 0, 0, 0);
            if (gate_open) opened++;
            if (timeout_err) begin pulses++; pulse_at = i; end
        end
        chk("auth_tmo_pulses", 32'(pulses), 32'd1);
        chk("auth_tmo_cycle", 32'(pulse_at), 32'(AUTH_C));
        chk("auth_tmo_closed", 32'(opened), 32'd0);
        chk("auth_tmo_occ", 32'(occupancy), 32'd0);
        cycle(1, 1, 0, 0);
        chk("auth_tmo_rr", 32'({entry_grant, exit_grant}), 32'b01);

        // Exit OPEN: car_cleared on the cycle the timer reads 0.
        do_reset();
        admit();
        cycle(0, 1, 0, 0);
        repeat (OPEN_C) cycle(0, 0, 0, 0);
        chk("open_edge_hold", 32'({exit_grant, timeout_err}), 32'b10);
        cycle(0, 0, 0, 1);
        chk("open_edge_tmo", 32'(timeout_err), 32'd0);
        chk("open_edge_occ", 32'(occupancy), 32'd0);
        repeat (CLOSE_C) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat (OPEN_C) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("open_tmo", 32'({timeout_err, gate_open}), 32'b10);

        // Reset asserted during OPEN.
        do_reset();
        admit();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        rst_in = 0;
        #1;
        chk("rst_mid_gate", 32'(gate_open), 32'd0);
        chk("rst_mid_occ", 32'(occupancy), 32'd0);
        model_reset();
        chk("rst_mid_model", 32'(dut_vec()), 32'(exp_vec()));
        @(posedge clock_in);
        #1 rst_in = 1;
        cycle(1, 1, 0, 0);
        chk("rst_mid_first", 32'({entry_grant, exit_grant}), 32'b10);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
